// File: rtl/cordic_ch_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_ch_scheduler
//   Shares one CORDIC sin/cos pipeline between NCH NCO channels.
//   Each channel has a 32-bit phase accumulator, a tuning word (FTW), a phase
//   offset (POFF) and an enable bit. Enabled channels are served round-robin.
//   Every issued phase word is tagged with its channel. Returning sin/cos
//   samples are paired with their tags and buffered for a valid/ready consumer.
//   The CORDIC has no backpressure, so issue is limited by credits. One credit
//   is held for each free output FIFO slot, which means no result is ever lost.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset (also resets CORDIC)
//   run_i              global issue enable
//   cfg_we_i           config write strobe
//   cfg_addr_i         {ch, sel}: 0=FTW 1=POFF 2=ENABLE(bit0) 3=ACC clear
//   cfg_wdata_i        config write data
//   cordic_valid_o     phase word valid towards the CORDIC
//   cordic_phase_o     phase word towards the CORDIC (2^32 = 2*pi)
//   cordic_valid_i     result valid from the CORDIC
//   cordic_sin_i/cos_i result samples, signed Q1.15
//   m_valid_o/ready_i  output handshake (first-word-fall-through)
//   m_ch_o             channel of the output sample
//   m_sin_o/m_cos_o    output sample
//   err_o              sticky: a result arrived with no tag outstanding
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cordic_ch_scheduler_fifo
//   Small first-word-fall-through FIFO. The caller guarantees that it never
//   pushes when the FIFO is full and never pops when it is empty.
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push, wdata    write side
//   pop, rdata     read side; rdata shows the head entry while !empty
//   empty          no entries stored
// ---------------------------------------------------------------------------
module cordic_ch_scheduler_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; the contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module cordic_ch_scheduler #(
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    input  logic            cfg_we_i,
    input  logic [CH_W+1:0] cfg_addr_i,
    input  logic [31:0]     cfg_wdata_i,
    output logic            cordic_valid_o,
    output logic [31:0]     cordic_phase_o,
    input  logic            cordic_valid_i,
    input  logic [15:0]     cordic_sin_i,
    input  logic [15:0]     cordic_cos_i,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [CH_W-1:0] m_ch_o,
    output logic [15:0]     m_sin_o,
    output logic [15:0]     m_cos_o,
    output logic            err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Per-channel NCO state
    logic [31:0]     acc_q  [NCH];
    logic [31:0]     ftw_q  [NCH];
    logic [31:0]     poff_q [NCH];
    logic [NCH-1:0]  en_q;
    logic [CH_W-1:0] rr_ptr_q;
    logic [CW-1:0]   credits_q;

    // Config decode
    logic [CH_W-1:0] cfg_ch;
    logic [1:0]      cfg_sel;

    assign cfg_ch  = cfg_addr_i[CH_W+1:2];
    assign cfg_sel = cfg_addr_i[1:0];

    // Round-robin selection: first enabled channel at or after rr_ptr
    logic [CH_W-1:0] sel_ch;
    logic [CH_W-1:0] cand;
    logic            sel_found;
    logic            issue;

    always_comb begin
        sel_ch    = rr_ptr_q;
        sel_found = 1'b0;
        cand      = rr_ptr_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = rr_ptr_q + CH_W'(i);
            if (!sel_found && en_q[cand]) begin
                sel_ch    = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign issue = run_i && (credits_q != '0) && sel_found;

    // Tag and output FIFOs
    logic            tag_empty;
    logic [CH_W-1:0] tag_head;
    logic            tag_pop;
    logic            drop;
    logic            out_empty;
    logic            out_pop;
    logic [CH_W+31:0] out_head;

    assign tag_pop = cordic_valid_i && !tag_empty;
    assign drop    = cordic_valid_i && tag_empty;
    assign out_pop = m_valid_o && m_ready_i;

    cordic_ch_scheduler_fifo #(
        .W     (CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (issue),
        .wdata (sel_ch),
        .pop   (tag_pop),
        .rdata (tag_head),
        .empty (tag_empty)
    );

    cordic_ch_scheduler_fifo #(
        .W     (CH_W + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tag_pop),
        .wdata ({tag_head, cordic_sin_i, cordic_cos_i}),
        .pop   (out_pop),
        .rdata (out_head),
        .empty (out_empty)
    );

    // Data outputs are forced to zero while nothing is valid, so that the
    // unreset FIFO storage never shows up on the ports after reset.
    assign m_valid_o = !out_empty;
    assign m_ch_o    = m_valid_o ? out_head[CH_W+31:32] : '0;
    assign m_sin_o   = m_valid_o ? out_head[31:16]      : '0;
    assign m_cos_o   = m_valid_o ? out_head[15:0]       : '0;

    // Issue, credits, configuration and error state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                ftw_q[i]  <= '0;
                poff_q[i] <= '0;
            end
            en_q           <= '0;
            rr_ptr_q       <= '0;
            credits_q      <= CW'(FIFO_DEPTH);
            cordic_valid_o <= 1'b0;
            cordic_phase_o <= '0;
            err_o          <= 1'b0;
        end else begin
            cordic_valid_o <= issue;
            if (issue) begin
                cordic_phase_o  <= acc_q[sel_ch] + poff_q[sel_ch];
                acc_q[sel_ch]   <= acc_q[sel_ch] + ftw_q[sel_ch];
                rr_ptr_q        <= sel_ch + CH_W'(1);
            end

            case ({issue, out_pop})
                2'b10:   credits_q <= credits_q - CW'(1);
                2'b01:   credits_q <= credits_q + CW'(1);
                default: credits_q <= credits_q;
            endcase

            if (drop) begin
                err_o <= 1'b1;
            end

            // Placed after the issue update so an ACC clear overrides a
            // coincident accumulate of the same channel.
            if (cfg_we_i) begin
                case (cfg_sel)
                    2'd0:    ftw_q[cfg_ch]  <= cfg_wdata_i;
                    2'd1:    poff_q[cfg_ch] <= cfg_wdata_i;
                    2'd2:    en_q[cfg_ch]   <= cfg_wdata_i[0];
                    default: acc_q[cfg_ch]  <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cordic_ch_scheduler.sv
module tb_cordic_ch_scheduler;
    localparam int NCH  = 4;
    localparam int CH_W = 2;
    localparam int FD   = 32;
    localparam int LAT  = 6;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            run_i;
    logic            cfg_we_i;
    logic [CH_W+1:0] cfg_addr_i;
    logic [31:0]     cfg_wdata_i;
    logic            cordic_valid_o;
    logic [31:0]     cordic_phase_o;
    logic            cordic_valid_i;
    logic [15:0]     cordic_sin_i;
    logic [15:0]     cordic_cos_i;
    logic            m_valid_o;
    logic            m_ready_i;
    logic [CH_W-1:0] m_ch_o;
    logic [15:0]     m_sin_o;
    logic [15:0]     m_cos_o;
    logic            err_o;
    logic            inj_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cordic_ch_scheduler #(
        .NCH        (NCH),
        .CH_W       (CH_W),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .run_i          (run_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .cordic_valid_o (cordic_valid_o),
        .cordic_phase_o (cordic_phase_o),
        .cordic_valid_i (cordic_valid_i),
        .cordic_sin_i   (cordic_sin_i),
        .cordic_cos_i   (cordic_cos_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_ch_o         (m_ch_o),
        .m_sin_o        (m_sin_o),
        .m_cos_o        (m_cos_o),
        .err_o          (err_o)
    );

    // CORDIC stand-in: quarter-turn phases give ideal Q1.15 values, any other
    // phase returns a tracer (sin = phase[31:16], cos = ~phase[31:16]).
    function automatic logic [31:0] model_sc(input logic [31:0] ph);
        if (ph[29:0] == 30'd0) begin
            case (ph[31:30])
                2'd0:    return {16'h0000, 16'h7FFF};
                2'd1:    return {16'h7FFF, 16'h0000};
                2'd2:    return {16'h0000, 16'h8001};
                default: return {16'h8001, 16'h0000};
            endcase
        end
        return {ph[31:16], ~ph[31:16]};
    endfunction

    logic [LAT-1:0] pv;
    logic [31:0]    pph [LAT];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pph[i] <= '0;
        end else begin
            pv     <= {pv[LAT-2:0], cordic_valid_o};
            pph[0] <= cordic_phase_o;
            for (int i = 1; i < LAT; i++) pph[i] <= pph[i-1];
        end
    end

    assign cordic_valid_i = pv[LAT-1] | inj_valid;
    assign {cordic_sin_i, cordic_cos_i} = model_sc(pph[LAT-1]);

    // Monitor: record issued phase words and consumed output samples
    int unsigned     cyc = 0;
    logic [31:0]     iss_ph  [$];
    int unsigned     iss_cyc [$];
    logic [CH_W-1:0] out_ch  [$];
    logic [15:0]     out_sin [$];
    logic [15:0]     out_cos [$];

    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (cordic_valid_o) begin
            iss_ph.push_back(cordic_phase_o);
            iss_cyc.push_back(cyc);
        end
        if (m_valid_o && m_ready_i) begin
            out_ch.push_back(m_ch_o);
            out_sin.push_back(m_sin_o);
            out_cos.push_back(m_cos_o);
        end
    end

    task automatic clear_logs();
        iss_ph.delete();
        iss_cyc.delete();
        out_ch.delete();
        out_sin.delete();
        out_cos.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1; run_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
        cfg_wdata_i = '0; m_ready_i = 1'b0; inj_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        clear_logs();
    endtask

    task automatic cfg_write(input int ch, input int sel, input logic [31:0] d);
        @(posedge clk_i); #1;
        cfg_we_i = 1'b1; cfg_addr_i = {2'(ch), 2'(sel)}; cfg_wdata_i = d;
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0;
    endtask

    // run_i is high for exactly k sampling edges -> k decision cycles
    task automatic run_for(input int k);
        @(posedge clk_i); #1 run_i = 1'b1;
        repeat (k) @(posedge clk_i);
        #1 run_i = 1'b0;
    endtask

    task automatic run_with_cfg(input int k, input int ch, input int sel, input logic [31:0] d);
        @(posedge clk_i); #1;
        run_i = 1'b1;
        cfg_we_i = 1'b1; cfg_addr_i = {2'(ch), 2'(sel)}; cfg_wdata_i = d;
        @(posedge clk_i); #1 cfg_we_i = 1'b0;
        repeat (k-1) @(posedge clk_i);
        #1 run_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; run_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
        cfg_wdata_i = '0; m_ready_i = 1'b0; inj_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (cordic_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cvalid: got %b expected 0", cordic_valid_o); end
        n_checks++; if (cordic_phase_o !== 32'h0) begin n_fail++; $display("FAIL reset_phase: got %h expected 0", cordic_phase_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 0", m_valid_o); end
        n_checks++; if ({m_ch_o, m_sin_o, m_cos_o} !== '0) begin n_fail++; $display("FAIL reset_mdata: got %h expected 0", {m_ch_o, m_sin_o, m_cos_o}); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [31:0] ep;
        do_reset();
        cfg_write(0, 0, 32'h4000_0000);
        cfg_write(0, 2, 32'h1);
        m_ready_i = 1'b1;
        run_for(20);
        repeat (20) @(posedge clk_i);
        n_checks++; if (iss_ph.size() != 20) begin n_fail++; $display("FAIL single_issue_count: got %0d expected 20", iss_ph.size()); end
        n_checks++; if (out_ch.size() != 20) begin n_fail++; $display("FAIL single_out_count: got %0d expected 20", out_ch.size()); end
        ep = 32'h0;
        for (int i = 0; i < iss_ph.size() && i < 8; i++) begin
            n_checks++; if (iss_ph[i] !== ep) begin n_fail++; $display("FAIL single_phase[%0d]: got %h expected %h", i, iss_ph[i], ep); end
            ep = ep + 32'h4000_0000;
        end
        for (int i = 1; i < iss_cyc.size(); i++) begin
            n_checks++; if (iss_cyc[i] != iss_cyc[0] + i) begin n_fail++; $display("FAIL single_rate[%0d]: got cycle %0d expected %0d", i, iss_cyc[i], iss_cyc[0] + i); end
        end
        ep = 32'h0;
        for (int i = 0; i < out_ch.size(); i++) begin
            n_checks++; if ({out_ch[i], out_sin[i], out_cos[i]} !== {2'd0, model_sc(ep)}) begin
                n_fail++; $display("FAIL single_sample[%0d]: got %h expected %h", i, {out_ch[i], out_sin[i], out_cos[i]}, {2'd0, model_sc(ep)});
            end
            ep = ep + 32'h4000_0000;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ch  [9] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [15:0] exp_sin [9] = '{16'h0200, 16'h0400, 16'h0800, 16'h0300, 16'h0600,
                                     16'h0C00, 16'h0400, 16'h0800, 16'h1000};
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            cfg_write(c, 0, 32'((c + 1) << 24));
            cfg_write(c, 2, 32'h1);
        end
        m_ready_i = 1'b1;
        run_for(8);
        repeat (20) @(posedge clk_i);
        n_checks++; if (out_ch.size() != 8) begin n_fail++; $display("FAIL rr4_count: got %0d expected 8", out_ch.size()); end
        for (int i = 0; i < out_ch.size(); i++) begin
            n_checks++; if (out_ch[i] !== 2'(i)) begin n_fail++; $display("FAIL rr4_ch[%0d]: got %0d expected %0d", i, out_ch[i], i % 4); end
        end
        cfg_write(2, 2, 32'h0);
        clear_logs();
        run_for(9);
        repeat (20) @(posedge clk_i);
        n_checks++; if (out_ch.size() != 9) begin n_fail++; $display("FAIL rr3_count: got %0d expected 9", out_ch.size()); end
        for (int i = 0; i < out_ch.size() && i < 9; i++) begin
            n_checks++; if ({out_ch[i], out_sin[i]} !== {exp_ch[i], exp_sin[i]}) begin
                n_fail++; $display("FAIL rr3_sample[%0d]: got ch %0d sin %h expected ch %0d sin %h", i, out_ch[i], out_sin[i], exp_ch[i], exp_sin[i]);
            end
        end
        for (int i = 1; i < iss_cyc.size(); i++) begin
            n_checks++; if (iss_cyc[i] != iss_cyc[0] + i) begin n_fail++; $display("FAIL rr3_gap[%0d]: got cycle %0d expected %0d", i, iss_cyc[i], iss_cyc[0] + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ep;
        do_reset();
        cfg_write(0, 0, 32'h0001_0000);
        cfg_write(0, 2, 32'h1);
        m_ready_i = 1'b0;
        @(posedge clk_i); #1 run_i = 1'b1;
        repeat (100) @(posedge clk_i);
        #1;
        n_checks++; if (iss_ph.size() != FD) begin n_fail++; $display("FAIL bp_issue_count: got %0d expected %0d", iss_ph.size(), FD); end
        n_checks++; if (cordic_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_cvalid_stop: got %b expected 0", cordic_valid_o); end
        n_checks++; if ({m_valid_o, m_ch_o, m_sin_o, m_cos_o} !== {1'b1, 2'd0, 16'h0000, 16'h7FFF}) begin
            n_fail++; $display("FAIL bp_head_hold: got %h expected %h", {m_valid_o, m_ch_o, m_sin_o, m_cos_o}, {1'b1, 2'd0, 16'h0000, 16'h7FFF});
        end
        m_ready_i = 1'b1;
        repeat (60) @(posedge clk_i);
        #1 run_i = 1'b0;
        repeat (40) @(posedge clk_i);
        n_checks++; if (iss_ph.size() <= FD) begin n_fail++; $display("FAIL bp_resume: got %0d issues expected more than %0d", iss_ph.size(), FD); end
        n_checks++; if (out_ch.size() != iss_ph.size()) begin n_fail++; $display("FAIL bp_drain: got %0d outputs expected %0d", out_ch.size(), iss_ph.size()); end
        ep = 32'h0;
        for (int i = 0; i < out_ch.size(); i++) begin
            n_checks++; if ({out_sin[i], out_cos[i]} !== model_sc(ep)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, {out_sin[i], out_cos[i]}, model_sc(ep));
            end
            ep = ep + 32'h0001_0000;
        end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b expected 0", err_o); end
    endtask

    task automatic test_poff_clear();
        logic [31:0] exp_ph [9] = '{32'h8000_0000, 32'h8100_0000, 32'h8200_0000,
                                    32'h8300_0000, 32'h8000_0000, 32'h8100_0000,
                                    32'h8200_0000, 32'h8300_0000, 32'h8310_0000};
        do_reset();
        cfg_write(1, 1, 32'h8000_0000);
        cfg_write(1, 0, 32'h0100_0000);
        cfg_write(1, 2, 32'h1);
        m_ready_i = 1'b1;
        run_for(3);
        run_with_cfg(3, 1, 3, 32'h0);
        run_with_cfg(2, 1, 0, 32'h0010_0000);
        run_for(1);
        repeat (20) @(posedge clk_i);
        n_checks++; if (iss_ph.size() != 9) begin n_fail++; $display("FAIL poff_count: got %0d expected 9", iss_ph.size()); end
        for (int i = 0; i < iss_ph.size() && i < 9; i++) begin
            n_checks++; if (iss_ph[i] !== exp_ph[i]) begin n_fail++; $display("FAIL poff_phase[%0d]: got %h expected %h", i, iss_ph[i], exp_ph[i]); end
        end
        for (int i = 0; i < out_ch.size(); i++) begin
            n_checks++; if (out_ch[i] !== 2'd1) begin n_fail++; $display("FAIL poff_ch[%0d]: got %0d expected 1", i, out_ch[i]); end
        end
    endtask

    task automatic test_err();
        do_reset();
        m_ready_i = 1'b1;
        #1;
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b expected 0", err_o); end
        @(posedge clk_i); #1 inj_valid = 1'b1;
        @(posedge clk_i); #1 inj_valid = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_mvalid: got %b expected 0", m_valid_o); end
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_mvalid_late: got %b expected 0", m_valid_o); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cfg_write(0, 0, 32'h0001_0000);
        cfg_write(0, 2, 32'h1);
        m_ready_i = 1'b0;
        @(posedge clk_i); #1 run_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++; if ({cordic_valid_o, m_valid_o} !== 2'b11) begin n_fail++; $display("FAIL mid_active: got %b expected 11", {cordic_valid_o, m_valid_o}); end
        #2 rst_i = 1'b1;
        #1;
        n_checks++; if ({cordic_valid_o, cordic_phase_o} !== 33'h0) begin n_fail++; $display("FAIL mid_cordic_out: got %h expected 0", {cordic_valid_o, cordic_phase_o}); end
        n_checks++; if ({m_valid_o, m_ch_o, m_sin_o, m_cos_o, err_o} !== '0) begin
            n_fail++; $display("FAIL mid_m_out: got %h expected 0", {m_valid_o, m_ch_o, m_sin_o, m_cos_o, err_o});
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
        clear_logs();
        repeat (10) @(posedge clk_i);
        n_checks++; if (iss_ph.size() != 0) begin n_fail++; $display("FAIL mid_no_issue: got %0d issues expected 0", iss_ph.size()); end
        cfg_write(0, 2, 32'h1);
        repeat (100) @(posedge clk_i);
        n_checks++; if (iss_ph.size() != FD) begin n_fail++; $display("FAIL mid_credits: got %0d issues expected %0d", iss_ph.size(), FD); end
        #1 run_i = 1'b0; m_ready_i = 1'b1;
        repeat (60) @(posedge clk_i);
        n_checks++; if (out_ch.size() != FD) begin n_fail++; $display("FAIL mid_drain: got %0d outputs expected %0d", out_ch.size(), FD); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_poff_clear();
        test_err();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
